spi_dac_multi: RTL
==================

SPI_DAC_MULTI -- requirements
Module: spi_dac_multi

Interface
REQ-001 Parameter DATA_W, default 16: sample width per channel, allowed range 4..24.
REQ-002 Parameter N_CH, default 4: channel count, allowed range 1..8.
REQ-003 Parameter ADDR_W, default 2: address field width; must satisfy 2**ADDR_W >= N_CH.
REQ-004 Parameter CLK_DIV, default 1: spi_clk_o half-period in clk_i cycles, allowed range 1..255.
REQ-005 Parameter OFFSET_BIN, default 1: 1 converts two's-complement input to offset binary; 0 sends the input unchanged.
REQ-006 Parameter GAP_CYC, default 2: cycles spi_cs_o stays high between consecutive frames, allowed range 1..255.
REQ-007 clk_i  in  1  clock; the only clock.
REQ-008 reset_ni  in  1  reset, synchronous and active-low.
REQ-009 data_i  in  N_CH*DATA_W  signed samples; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 ch_mask_i  in  N_CH  channels to update; bit k=1 selects channel k.
REQ-011 start_i  in  1  level request to start a burst.
REQ-012 is_idle_o  out  1  1 only in IDLE.
REQ-013 done_o  out  1  one-cycle pulse on entry to DONE.
REQ-014 spi_clk_o  out  1  SPI clock, idle low (mode 0).
REQ-015 spi_mosi_o  out  1  SPI data, MSB first.
REQ-016 spi_cs_o  out  1  active-low chip select.
REQ-017 dac_reset_no  out  1  DAC reset; equals reset_ni combinationally.

Function
REQ-018 States SHALL be IDLE, CS_DOWN, CLK_LO, CLK_HI, GAP and DONE; any unused state encoding returns to IDLE on the next cycle.
REQ-019 In IDLE with start_i=1, the block SHALL latch data_i and ch_mask_i into internal registers; later changes to the inputs have no effect on the burst.
REQ-020 If the latched mask is nonzero, the next state SHALL be CS_DOWN with the lowest set channel selected; if it is zero, the next state SHALL be DONE and spi_cs_o SHALL stay high.
REQ-021 Frame SHALL be FRAME_W = ADDR_W + DATA_W bits, sent MSB first: channel index (ADDR_W bits), then the converted sample.
REQ-022 Conversion with OFFSET_BIN=1 SHALL invert the sample MSB, equivalent to adding 2**(DATA_W-1) modulo 2**DATA_W; with OFFSET_BIN=0 there is no change.
REQ-023 CS_DOWN SHALL last 1 cycle with spi_cs_o=0, spi_clk_o=0 and spi_mosi_o equal to the frame MSB; the next state is CLK_LO.
REQ-024 CLK_LO and CLK_HI SHALL each last CLK_DIV cycles; spi_clk_o=1 only in CLK_HI.
REQ-025 spi_mosi_o SHALL hold the current bit throughout CLK_LO and CLK_HI and change only on entry to the next CLK_LO.
REQ-026 After CLK_HI of bit 0, the block SHALL go to GAP if a higher set mask bit remains, otherwise to DONE.
REQ-027 The bit counter SHALL reload to FRAME_W-1 at each CS_DOWN and SHALL NOT underflow.
REQ-028 spi_cs_o SHALL be low in CS_DOWN, CLK_LO and CLK_HI only, and high in IDLE, GAP and DONE.
REQ-029 GAP SHALL last GAP_CYC cycles and then enter CS_DOWN with the next set channel.
REQ-030 Cycles with spi_cs_o low per frame SHALL equal 1 + 2*CLK_DIV*FRAME_W.
REQ-031 DONE SHALL persist while start_i=1 and return to IDLE on the first cycle start_i=0; exactly one burst runs per start_i assertion.
REQ-032 spi_mosi_o SHALL be 0 whenever spi_cs_o=1.

Reset
REQ-033 While reset_ni=0 at a clk_i edge: state goes to IDLE, counters clear, latched data is set to 0 and latched mask to 0.
REQ-034 Outputs during and after reset SHALL be: is_idle_o=1, done_o=0, spi_clk_o=0, spi_mosi_o=0, spi_cs_o=1, dac_reset_no=0 (while reset_ni=0).
REQ-035 Reset asserted mid-frame SHALL abort the burst, with spi_cs_o=1 and spi_clk_o=0 from the cycle after the reset edge.

Verification
REQ-036 Defaults, mask=4'b0001, ch0=16'sh0000, start pulse -> one frame of 18 bits 00_1000000000000000; spi_cs_o low for 37 cycles; done_o pulses once.
REQ-037 Defaults, mask=4'b1010, ch1=-1, ch3=16'sh7FFF -> frame 01_0111111111111111, then cs high for 2 cycles, then frame 11_1111111111111111.
REQ-038 CLK_DIV=3, DATA_W=12, ADDR_W=3, N_CH=8, mask=8'h80 -> spi_clk_o high/low periods of exactly 3 cycles; 15 rising edges; cs low for 91 cycles.
REQ-039 mask=0 with start held high for 10 cycles -> no cs activity; done_o pulses once; IDLE is reached one cycle after start_i falls.
REQ-040 reset_ni=0 at bit 7 of frame 2 -> spi_cs_o=1 and spi_clk_o=0 on the next cycle; a new start afterwards produces a complete, correct burst.
REQ-041 OFFSET_BIN=0, ch0=16'sh8000 -> data field 1000000000000000; data_i changed mid-burst does not alter the transmitted bits.

Source files
------------

// File: rtl/spi_dac_multi.sv
// spi_dac_multi
// Multi-channel SPI DAC writer. On a start request it captures one sample per
// channel plus a channel mask. It then sends one SPI mode-0 frame for each
// selected channel, lowest channel first. Each frame is {channel index,
// converted sample}, sent MSB first, and consecutive frames are separated by a
// chip-select-high gap.
//
// Ports
//   clk_i        : the only clock
//   reset_ni     : synchronous active-low reset
//   data_i       : N_CH signed samples, channel k at [k*DATA_W +: DATA_W]
//   ch_mask_i    : channel select mask, bit k selects channel k
//   start_i      : level request; exactly one burst runs per assertion
//   is_idle_o    : high only in IDLE
//   done_o       : one-cycle pulse on entry to DONE
//   spi_clk_o    : SPI clock, idles low
//   spi_mosi_o   : SPI data, MSB first, 0 whenever chip select is high
//   spi_cs_o     : active-low chip select
//   dac_reset_no : DAC reset, a combinational copy of reset_ni
//   state_dbg_o  : current FSM state encoding, for observation only
//
// Handshake: start_i is sampled only in IDLE. While DONE, the block waits for
// start_i to drop before returning to IDLE, so a held request cannot start a
// second burst.
module spi_dac_multi #(
  parameter int DATA_W     = 16,
  parameter int N_CH       = 4,
  parameter int ADDR_W     = 2,
  parameter int CLK_DIV    = 1,
  parameter int OFFSET_BIN = 1,
  parameter int GAP_CYC    = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [N_CH*DATA_W-1:0] data_i,
  input  logic [N_CH-1:0]        ch_mask_i,
  input  logic                   start_i,
  output logic                   is_idle_o,
  output logic                   done_o,
  output logic                   spi_clk_o,
  output logic                   spi_mosi_o,
  output logic                   spi_cs_o,
  output logic                   dac_reset_no,
  output logic [2:0]             state_dbg_o
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CS_DOWN = 3'd1,
    CLK_LO  = 3'd2,
    CLK_HI  = 3'd3,
    GAP     = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic [N_CH*DATA_W-1:0]   data_q, data_d;
  logic [N_CH-1:0]          mask_q, mask_d;
  logic [ADDR_W-1:0]        ch_q, ch_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     done_q, done_d;

  logic                     first_found, next_found;
  logic [ADDR_W-1:0]        first_ch, next_ch;
  logic [DATA_W-1:0]        sample, conv;
  logic [FRAME_W-1:0]       frame;
  logic                     cs_active;

  // Lowest set bit of the incoming mask, and the lowest set bit of the
  // captured mask strictly above the current channel. Scanning downward lets
  // the last hit, which is the lowest index, win.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (ch_mask_i[k]) begin
        first_found = 1'b1;
        first_ch    = ADDR_W'(k);
      end
      if (mask_q[k] && (k > int'(ch_q))) begin
        next_found = 1'b1;
        next_ch    = ADDR_W'(k);
      end
    end
  end

  // Frame assembly for the current channel.
  always_comb begin
    sample = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_q == ADDR_W'(k)) sample = data_q[k*DATA_W +: DATA_W];
    end
    conv = sample;
    // Inverting the MSB maps two's complement onto offset binary.
    if (OFFSET_BIN != 0) conv[DATA_W-1] = ~sample[DATA_W-1];
    frame = {ch_q, conv};
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          data_d = data_i;
          mask_d = ch_mask_i;
          if (first_found) begin
            ch_d    = first_ch;
            bit_d   = BIT_TOP;
            state_d = CS_DOWN;
          end else begin
            state_d = DONE;
          end
        end
      end
      CS_DOWN: begin
        cnt_d   = '0;
        state_d = CLK_LO;
      end
      CLK_LO: begin
        if (cnt_q == 8'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = CLK_HI;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CLK_HI: begin
        if (cnt_q == 8'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (bit_q != '0) begin
            // The next bit appears on entry to CLK_LO.
            bit_d   = bit_q - 1'b1;
            state_d = CLK_LO;
          end else if (next_found) begin
            ch_d    = next_ch;
            state_d = GAP;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          bit_d   = BIT_TOP;
          state_d = CS_DOWN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (!start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      ch_q    <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign cs_active    = (state_q == CS_DOWN) || (state_q == CLK_LO) || (state_q == CLK_HI);
  assign spi_cs_o     = ~cs_active;
  assign spi_clk_o    = (state_q == CLK_HI);
  assign spi_mosi_o   = cs_active & frame[bit_q];
  assign is_idle_o    = (state_q == IDLE);
  assign done_o       = done_q;
  assign dac_reset_no = reset_ni;
  assign state_dbg_o  = state_q;

endmodule
